// File: rtl/imm_gen_pkg.sv
// Shared types for the immediate-generation stage.
// Formats, base opcodes and the buffered entry layout.
package imm_gen_pkg;

   typedef enum logic [2:0] {
      FMT_NONE,
      FMT_R,
      FMT_I,
      FMT_S,
      FMT_B,
      FMT_U,
      FMT_J
   } imm_fmt_e;

   localparam logic [6:0] OPC_LOAD    = 7'b0000011;
   localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
   localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
   localparam logic [6:0] OPC_JALR    = 7'b1100111;
   localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
   localparam logic [6:0] OPC_STORE   = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
   localparam logic [6:0] OPC_LUI     = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
   localparam logic [6:0] OPC_JAL     = 7'b1101111;
   localparam logic [6:0] OPC_OP      = 7'b0110011;
   localparam logic [6:0] OPC_OP32    = 7'b0111011;

   localparam int XLEN_MAX = 64;
   localparam int PC_W_MAX = 64;

   // Sized for the widest build; narrower builds leave the top bits zero.
   typedef struct packed {
      logic                valid;
      logic [31:0]         inst;
      logic [PC_W_MAX-1:0] pc;
      logic [XLEN_MAX-1:0] imm;
      imm_fmt_e            fmt;
      logic                illegal;
   } imm_entry_t;

   function automatic logic [XLEN_MAX-1:0] sext32(input logic [31:0] v);
      return {{(XLEN_MAX-32){v[31]}}, v};
   endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational format classifier and immediate extractor.
// Every format is first built as a 32-bit value, then sign-extended.
module imm_decode
   import imm_gen_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     inst,
   output logic [XLEN-1:0] imm,
   output imm_fmt_e        fmt,
   output logic            illegal
);

   localparam bit RV64 = (XLEN == 64);

   logic [6:0]  opc;
   logic [31:0] raw;
   logic        is_r;
   logic        is_i;
   logic        is_s;
   logic        is_b;
   logic        is_u;
   logic        is_j;

   assign opc = inst[6:0];

   assign is_r = (opc == OPC_OP)
              || (RV64 && opc == OPC_OP32);
   assign is_i = (opc == OPC_LOAD)
              || (opc == OPC_OPIMM)
              || (opc == OPC_JALR)
              || (opc == OPC_SYSTEM)
              || (RV64 && opc == OPC_OPIMM32);
   assign is_s = (opc == OPC_STORE);
   assign is_b = (opc == OPC_BRANCH);
   assign is_u = (opc == OPC_LUI)
              || (opc == OPC_AUIPC);
   assign is_j = (opc == OPC_JAL);

   always_comb begin
      raw     = '0;
      fmt     = FMT_NONE;
      illegal = 1'b0;
      unique case (1'b1)
         is_r: fmt = FMT_R;
         is_i: begin
            fmt = FMT_I;
            raw = {{20{inst[31]}}, inst[31:20]};
         end
         is_s: begin
            fmt = FMT_S;
            raw = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         end
         is_b: begin
            fmt = FMT_B;
            raw = {{19{inst[31]}}, inst[31], inst[7],
                   inst[30:25], inst[11:8], 1'b0};
         end
         is_u: begin
            fmt = FMT_U;
            raw = {inst[31:12], 12'b0};
         end
         is_j: begin
            fmt = FMT_J;
            raw = {{11{inst[31]}}, inst[31], inst[19:12],
                   inst[20], inst[30:21], 1'b0};
         end
         default: illegal = 1'b1;
      endcase
      imm = XLEN'(sext32(raw));
   end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage with a two-entry skid buffer.
// in_ready depends only on the skid register, never on out_ready.
module imm_gen_stage
   import imm_gen_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int PC_W = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_inst,
   input  logic [PC_W-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     out_inst,
   output logic [PC_W-1:0] out_pc,
   output logic [XLEN-1:0] out_imm,
   output logic [2:0]      out_fmt,
   output logic            out_illegal
);

   imm_entry_t      main_q;
   imm_entry_t      skid_q;
   imm_entry_t      in_entry;
   logic [XLEN-1:0] dec_imm;
   imm_fmt_e        dec_fmt;
   logic            dec_illegal;
   logic            accept;
   logic            consume;
   logic            unused_pad;

   imm_decode #(
      .XLEN(XLEN)
   ) u_decode (
      .inst   (in_inst),
      .imm    (dec_imm),
      .fmt    (dec_fmt),
      .illegal(dec_illegal)
   );

   always_comb begin
      in_entry         = '0;
      in_entry.valid   = 1'b1;
      in_entry.inst    = in_inst;
      in_entry.pc      = PC_W_MAX'(in_pc);
      in_entry.imm     = XLEN_MAX'(dec_imm);
      in_entry.fmt     = dec_fmt;
      in_entry.illegal = dec_illegal;
   end

   assign in_ready = !skid_q.valid;
   assign accept   = in_valid && in_ready;
   assign consume  = main_q.valid && out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         main_q <= '0;
         skid_q <= '0;
      end else if (flush) begin
         main_q.valid <= 1'b0;
         skid_q.valid <= 1'b0;
      end else if (!main_q.valid || consume) begin
         // Skid drains first; accept is impossible while it is full.
         if (skid_q.valid) begin
            main_q       <= skid_q;
            skid_q.valid <= 1'b0;
         end else if (accept) begin
            main_q <= in_entry;
         end else begin
            main_q.valid <= 1'b0;
         end
      end else if (accept) begin
         skid_q <= in_entry;
      end
   end

   assign out_valid   = main_q.valid;
   assign out_inst    = main_q.inst;
   assign out_pc      = main_q.pc[PC_W-1:0];
   assign out_imm     = main_q.imm[XLEN-1:0];
   assign out_fmt     = main_q.fmt;
   assign out_illegal = main_q.illegal;

   assign unused_pad = ^{main_q.pc, main_q.imm};

endmodule
